nios_system_processor_gp_out: RTL and testbench

//  Avalon-MM slave output PIO: CPU-writable register driving out_port to board logic.

---
 rtl/nios_system_gp_out_pkg.sv | 24 ++
 rtl/nios_system_gp_out_pulse_timer.sv | 71 +++++++
 rtl/nios_system_processor_gp_out.sv | 127 ++++++++++++
 tb/tb_nios_system_processor_gp_out.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_gp_out_pkg.sv
// Shared definitions for the general-purpose output PIO.
// Holds the register map offsets and the pulse-timer state encoding.
// Imported by the pulse timer and by the top-level PIO.
package nios_system_gp_out_pkg;

  // Word offsets of the slave registers
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_OUTSET    = 3'd1;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;

  // Pulse timer states
  typedef enum logic {
    IDLE    = 1'b0,
    PULSING = 1'b1
  } pulse_state_e;

  // Avalon write strobe: chipselect qualified by the active-low write line
  function automatic logic bus_write(input logic cs, input logic wr_n);
    return cs & ~wr_n;
  endfunction

endpackage

// File: rtl/nios_system_gp_out_pulse_timer.sv
// Self-timed pulse counter: load arms it, expire fires on the last counted cycle.
// Latency: expire is combinational from the counter; state updates on the next edge.
// Any bus write in the expiry cycle holds off expiry by one cycle (counter parks at 1).
module nios_system_gp_out_pulse_timer
  import nios_system_gp_out_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_cancel,
  input  logic                 i_hold,
  output logic                 o_expire
);

  localparam logic [LEN_WIDTH-1:0] CNT_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] CNT_ZERO = '0;

  pulse_state_e         r_state;
  pulse_state_e         w_state_nxt;
  logic [LEN_WIDTH-1:0] r_count;
  logic [LEN_WIDTH-1:0] w_count_nxt;

  // The pulse ends when the counter reaches 1, unless a bus write claims this cycle
  assign o_expire = (r_state == PULSING) && (r_count == CNT_ONE) && !i_hold;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_count <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next state: load restarts, cancel stops, otherwise count down without wrapping
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (i_load) begin
      w_state_nxt = PULSING;
      w_count_nxt = i_len;
    end else if (i_cancel) begin
      w_state_nxt = IDLE;
      w_count_nxt = CNT_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          w_count_nxt = CNT_ZERO;
        end
        PULSING: begin
          if (o_expire) begin
            w_state_nxt = IDLE;
            w_count_nxt = CNT_ZERO;
          end else if (r_count > CNT_ONE) begin
            w_count_nxt = r_count - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/nios_system_processor_gp_out.sv
// Avalon-MM output PIO with atomic set/clear and self-timed pulse strobes.
// Latency: writes visible on out_port the cycle after; readdata registered, 1 cycle.
// Never stalls the bus: no waitrequest, every access completes immediately.
module nios_system_processor_gp_out
  import nios_system_gp_out_pkg::*;
#(
  parameter int                   WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int                   LEN_WIDTH   = 16,
  parameter logic [LEN_WIDTH-1:0] DEFAULT_LEN = LEN_WIDTH'(50)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]     r_data;
  logic [WIDTH-1:0]     r_mask;
  logic [LEN_WIDTH-1:0] r_len;
  logic [31:0]          r_readdata;

  logic [WIDTH-1:0]     w_data_nxt;
  logic [WIDTH-1:0]     w_mask_nxt;
  logic                 w_cancel;
  logic                 w_expire;
  logic [31:0]          w_rd_mux;

  logic                 w_wr;
  logic [WIDTH-1:0]     w_wd;
  logic [LEN_WIDTH-1:0] w_wlen;
  logic                 w_wr_data;
  logic                 w_wr_set;
  logic                 w_wr_clr;
  logic                 w_wr_pulse;
  logic                 w_wr_len;
  logic                 w_pulse_go;
  logic                 w_unused_wdata;

  // Bus decode; upper writedata bits are don't-care for every register
  assign w_wr           = bus_write(chipselect, write_n);
  assign w_wd           = writedata[WIDTH-1:0];
  assign w_wlen         = writedata[LEN_WIDTH-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_wr_data      = w_wr && (address == ADDR_DATA);
  assign w_wr_set       = w_wr && (address == ADDR_OUTSET);
  assign w_wr_clr       = w_wr && (address == ADDR_OUTCLEAR);
  assign w_wr_pulse     = w_wr && (address == ADDR_PULSE);
  assign w_wr_len       = w_wr && (address == ADDR_PULSE_LEN);

  // A pulse only starts when there is something to pulse and a non-zero length
  assign w_pulse_go     = w_wr_pulse && (w_wd != '0) && (r_len != '0);

  nios_system_gp_out_pulse_timer #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_timer (
    .clk      (clk),
    .i_reset  (reset),
    .i_load   (w_pulse_go),
    .i_len    (r_len),
    .i_cancel (w_cancel),
    .i_hold   (w_wr),
    .o_expire (w_expire)
  );

  // Data/mask update: a bus write always wins over pulse expiry
  always_comb begin
    w_data_nxt = r_data;
    w_mask_nxt = r_mask;
    w_cancel   = 1'b0;
    if (w_wr_data) begin
      w_data_nxt = w_wd;
      w_mask_nxt = '0;
      w_cancel   = 1'b1;
    end else if (w_wr_set) begin
      w_data_nxt = r_data | w_wd;
      w_mask_nxt = r_mask & ~w_wd;
      w_cancel   = ((r_mask & ~w_wd) == '0);
    end else if (w_wr_clr) begin
      w_data_nxt = r_data & ~w_wd;
      w_mask_nxt = r_mask & ~w_wd;
      w_cancel   = ((r_mask & ~w_wd) == '0);
    end else if (w_pulse_go) begin
      w_data_nxt = r_data | w_wd;
      w_mask_nxt = r_mask | w_wd;
    end else if (w_expire) begin
      w_data_nxt = r_data & ~r_mask;
      w_mask_nxt = '0;
    end
  end

  // Read mux from current register contents, zero-extended to the bus width
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: w_rd_mux = 32'(r_data);
      ADDR_PULSE:                            w_rd_mux = 32'(r_mask);
      ADDR_PULSE_LEN:                        w_rd_mux = 32'(r_len);
      default:                               w_rd_mux = '0;
    endcase
  end

  // Architectural registers and the registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data     <= RESET_VALUE;
      r_mask     <= '0;
      r_len      <= DEFAULT_LEN;
      r_readdata <= '0;
    end else begin
      r_data     <= w_data_nxt;
      r_mask     <= w_mask_nxt;
      r_readdata <= w_rd_mux;
      if (w_wr_len) begin
        r_len <= w_wlen;
      end
    end
  end

  assign out_port = r_data;
  assign readdata = r_readdata;

endmodule

// File: tb/tb_nios_system_processor_gp_out.sv
// Self-checking bench for the output PIO: directed scenarios plus random bus traffic.
// A deadline-based model predicts out_port and readdata every cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_nios_system_processor_gp_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  always #5 clk = ~clk;

  nios_system_processor_gp_out #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .LEN_WIDTH   (16),
    .DEFAULT_LEN (16'd50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: a pulse is an absolute deadline in cycles, not a counter
  int          cyc = 0;
  bit          m_valid = 0;
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [15:0] m_len;
  bit          m_puls;
  int          m_dead;
  logic [31:0] m_rd;

  always @(posedge clk) begin
    logic [7:0] w8;
    bit         wr;
    cyc++;
    w8 = writedata[7:0];
    wr = chipselect && !write_n;
    if (reset) begin
      m_valid = 1;
      m_data  = 8'hA5;
      m_mask  = 8'h00;
      m_len   = 16'd50;
      m_puls  = 0;
      m_dead  = 0;
      m_rd    = 32'h0;
    end else if (m_valid) begin
      case (address)
        3'd0, 3'd1, 3'd2: m_rd = {24'h0, m_data};
        3'd3:             m_rd = {24'h0, m_mask};
        3'd4:             m_rd = {16'h0, m_len};
        default:          m_rd = 32'h0;
      endcase
      if (wr) begin
        case (address)
          3'd0: begin m_data = w8; m_mask = 8'h00; m_puls = 0; end
          3'd1: begin m_data = m_data | w8; m_mask = m_mask & ~w8; if (m_mask == 0) m_puls = 0; end
          3'd2: begin m_data = m_data & ~w8; m_mask = m_mask & ~w8; if (m_mask == 0) m_puls = 0; end
          3'd3: if (w8 != 0 && m_len != 0) begin
                  m_data = m_data | w8;
                  m_mask = m_mask | w8;
                  m_dead = cyc + int'(m_len);
                  m_puls = 1;
                end
          3'd4: m_len = writedata[15:0];
          default: ;
        endcase
      end else if (m_puls && cyc >= m_dead) begin
        m_data = m_data & ~m_mask;
        m_mask = 8'h00;
        m_puls = 0;
      end
    end
    #1;
    if (m_valid) begin
      check("model_out_port", {24'h0, out_port}, {24'h0, m_data});
      check("model_readdata", readdata, m_rd);
    end
  end

  // One-cycle bus write, entered and left on a falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // One-cycle read; the value is the registered readdata after that edge
  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    v = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] r1, r6;
    int          hi;
    logic [15:0] lo16;

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_out_port", {24'h0, out_port}, 32'hA5);
    check("reset_readdata", readdata, 32'h0);
    reset = 1'b0;
    rd(3'd4, v);
    check("reset_pulse_len", v, 32'd50);

    // Plain, set and clear writes
    wr(3'd0, 32'h0000_003C); check("data_write", {24'h0, out_port}, 32'h3C);
    wr(3'd1, 32'hFFFF_FF81); check("outset",     {24'h0, out_port}, 32'hBD);
    wr(3'd2, 32'h1234_560C); check("outclear",   {24'h0, out_port}, 32'hB1);

    // Single pulse of length 4
    wr(3'd4, 32'hABCD_0004);
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h1);
    hi = int'(out_port[0]);
    r1 = 32'h0; r6 = 32'h0;
    chipselect = 1'b1; write_n = 1'b1; address = 3'd3;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      hi += int'(out_port[0]);
      if (k == 1) r1 = readdata;
      if (k == 6) r6 = readdata;
    end
    chipselect = 1'b0;
    check("pulse_high_cycles", 32'(hi), 32'd4);
    check("pulse_mask_active", r1, 32'h1);
    check("pulse_mask_done",   r6, 32'h0);

    // Retrigger merges the mask and restarts the count
    wr(3'd3, 32'h1);
    @(negedge clk);
    wr(3'd3, 32'h2);
    check("retrig_start", {24'h0, out_port}, 32'h03);
    repeat (3) @(negedge clk);
    check("retrig_held", {24'h0, out_port}, 32'h03);
    @(negedge clk);
    check("retrig_drop", {24'h0, out_port}, 32'h00);

    // OUTSET mid-pulse makes bit0 static
    wr(3'd3, 32'h3);
    wr(3'd1, 32'h1);
    check("static_mid", {24'h0, out_port}, 32'h03);
    repeat (5) @(negedge clk);
    check("static_after", {24'h0, out_port}, 32'h01);
    rd(3'd3, v);
    check("static_mask", v, 32'h0);

    // Write coinciding with expiry wins; expiry lands a cycle later
    wr(3'd4, 32'h1);
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h80);
    wr(3'd2, 32'h1);
    check("collide_write", {24'h0, out_port}, 32'h80);
    @(negedge clk);
    check("collide_expire", {24'h0, out_port}, 32'h00);

    // Reset aborts a running pulse
    wr(3'd4, 32'd10);
    wr(3'd3, 32'h0F);
    check("pre_reset_pulse", {24'h0, out_port}, 32'h0F);
    reset = 1'b1;
    @(negedge clk);
    check("midpulse_reset_out", {24'h0, out_port}, 32'hA5);
    reset = 1'b0;
    rd(3'd3, v);
    check("midpulse_reset_mask", v, 32'h0);
    repeat (12) @(negedge clk);
    check("midpulse_reset_hold", {24'h0, out_port}, 32'hA5);

    // Random traffic, short pulse lengths so expiries collide with writes often
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      chipselect = $urandom_range(0, 1) == 1;
      write_n    = ($urandom_range(0, 2) != 0);
      v          = 32'($urandom_range(0, 9));
      address    = (v > 7) ? 3'd3 : v[2:0];
      lo16       = 16'($urandom_range(0, 6));
      writedata  = $urandom;
      if (address == 3'd4) writedata[15:0] = lo16;
      @(negedge clk);
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
